// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter on the CPU data port. Stores to
//   TXDATA (BASE+0) queue a byte in a small circular FIFO; a shifter FSM
//   drains the FIFO onto `tx`. STATUS (BASE+4) is returned combinationally
//   so a single-cycle load sees it in the cycle it is issued.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   dataAddr   in  32   CPU data address
//   writeData  in  32   CPU store data (only [7:0] is used for TXDATA)
//   we         in   1   CPU store strobe
//   readData   out 32   STATUS word when addressed at BASE+4, else 0
//   sel        out  1   high when dataAddr is BASE+0 or BASE+4
//   tx         out  1   registered serial output, idles high
//
// STATUS layout: [0] full, [1] idle, [2] overflow (sticky), [15:8] count.

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        sel,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR;
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Shifter state
    state_e            state_q,   state_d;
    logic [BAUD_W-1:0] baud_q,    baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q,   shift_d;
    logic              tx_q,      tx_d;

    // FIFO and status state
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic hit_txdata, hit_status;
    logic wr_txdata, wr_status;
    logic fifo_full, fifo_empty;
    logic push, pop;
    logic baud_done;
    logic [31:0] status_word;

    // Upper store bits have no meaning for TXDATA.
    logic unused_wdata;
    assign unused_wdata = ^writeData[31:8];

    // ------------------------------------------------------------------
    // Address decode and FIFO flags
    // ------------------------------------------------------------------
    assign hit_txdata = (dataAddr == TXDATA_ADDR);
    assign hit_status = (dataAddr == STATUS_ADDR);
    assign wr_txdata  = we && hit_txdata;
    assign wr_status  = we && hit_status;

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);

    // Fullness is judged before the edge: a same-cycle pop never frees room.
    assign push       = wr_txdata && !fifo_full;
    assign baud_done  = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Shifter FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Shifter FSM: next state, baud/bit counters and pop request
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_mem_q[rd_ptr_q];
                        bit_idx_d = '0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shifter FSM: output decode (registered into tx_q one edge later)
    // ------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, count and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set and clear target different addresses, so they never collide.
        if (wr_txdata && fifo_full) begin
            overflow_d = 1'b1;
        end else if (wr_status) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is not reset; the count guarantees no entry is
    // read before it has been written, so a reset here would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= writeData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign status_word = {16'h0000, 8'(count_q), 5'b00000, overflow_q,
                          (fifo_empty && (state_q == S_IDLE)), fifo_full};

    assign readData = hit_status ? status_word : 32'h0000_0000;
    assign sel      = hit_txdata || hit_status;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A queue-based model predicts tx, sel and readData every cycle; directed
// sequences add literal expectations for the test-plan scenarios.

module tb_uart_tx_mmio;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STATUS = BASE + 32'd4;

    logic        clk;
    logic        reset;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic        we;
    logic [31:0] readData;
    logic        sel;
    logic        tx;

    int tests = 0;
    int fails = 0;

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dataAddr (dataAddr),
        .writeData(writeData),
        .we       (we),
        .readData (readData),
        .sel      (sel),
        .tx       (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue plus the frame currently on the line,
    // tracked as "cycles of the frame still to go".
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic [9:0] frame;
    logic [7:0] popped;
    int         frame_left = 0;
    int         pos;
    logic       m_ovf = 1'b0;
    logic       exp_tx = 1'b1;
    bit         model_valid = 1'b0;
    bit         m_store_tx, m_store_st, m_pop, m_push;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            frame_left  = 0;
            m_ovf       = 1'b0;
            exp_tx      = 1'b1;
            model_valid = 1'b1;
        end else if (model_valid) begin
            // tx after this edge shows the frame bit of the cycle just ended.
            if (frame_left > 0) begin
                pos    = 10 * CPB - frame_left;
                exp_tx = frame[pos / CPB];
            end else begin
                exp_tx = 1'b1;
            end
            m_store_tx = we && (dataAddr == BASE);
            m_store_st = we && (dataAddr == STATUS);
            m_pop      = (frame_left <= 1) && (mq.size() > 0);
            m_push     = m_store_tx && (mq.size() < DEPTH);
            if (m_store_tx && !m_push) m_ovf = 1'b1;
            if (m_store_st) m_ovf = 1'b0;
            if (frame_left > 0) frame_left--;
            if (m_pop) begin
                popped     = mq.pop_front();
                frame      = {1'b1, popped, 1'b0};
                frame_left = 10 * CPB;
            end
            if (m_push) mq.push_back(writeData[7:0]);
        end
    end

    logic [31:0] exp_status, exp_rd;
    always @(negedge clk) begin
        if (model_valid) begin
            exp_status = {16'h0, 8'(mq.size()), 5'h0, m_ovf,
                          ((mq.size() == 0) && (frame_left == 0)), (mq.size() == DEPTH)};
            exp_rd = (dataAddr == STATUS) ? exp_status : 32'h0;
            check("model_tx", {31'h0, tx}, {31'h0, exp_tx});
            check("model_sel", {31'h0, sel},
                  {31'h0, (dataAddr == BASE) || (dataAddr == STATUS)});
            check("model_readData", readData, exp_rd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dataAddr  = a;
        writeData = d;
        we        = 1'b1;
        @(posedge clk);
        #1;
        we        = 1'b0;
        dataAddr  = 32'h0;
        writeData = 32'h0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checks tx for cycles after the store edge against frames given LSB-first.
    task automatic check_frames(input string name, input logic [19:0] pats, input int nframes);
        logic exp_bit;
        for (int i = 0; i < 2 + 10 * CPB * nframes; i++) begin
            @(negedge clk);
            if (i < 2) exp_bit = 1'b1;
            else       exp_bit = pats[(i - 2) / CPB];
            check(name, {31'h0, tx}, {31'h0, exp_bit});
        end
    endtask

    logic [19:0] pat;

    initial begin
        reset     = 1'b1;
        we        = 1'b0;
        dataAddr  = STATUS;
        writeData = 32'h0;

        // Reset: tx high and STATUS idle throughout.
        repeat (3) begin
            @(negedge clk);
            check("reset_tx", {31'h0, tx}, 32'h1);
            check("reset_status", readData, 32'h0000_0002);
            check("reset_sel", {31'h0, sel}, 32'h1);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        dataAddr = 32'h0;
        idle_cycles(2);

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop.
        store(BASE, 32'hFFFF_FF55);
        pat = {10'b0, 10'b1010101010};
        check_frames("frame_55", pat, 1);
        @(posedge clk);
        #1;
        dataAddr = STATUS;
        @(negedge clk);
        check("status_after_55", readData, 32'h0000_0002);
        idle_cycles(3);

        // Back-to-back 0x41, 0x42 with no gap between the frames.
        store(BASE, 32'h0000_0041);
        store(BASE, 32'h0000_0042);
        pat = {10'b1010000100, 10'b1010000010};
        // check_frames counts from the first store edge; one cycle already passed.
        for (int i = 0; i < 1 + 10 * CPB * 2; i++) begin
            @(negedge clk);
            if (i == 0) check("b2b_lead", {31'h0, tx}, 32'h1);
            else        check("b2b_frames", {31'h0, tx}, {31'h0, pat[(i - 1) / CPB]});
        end
        idle_cycles(3);
        dataAddr = STATUS;
        @(negedge clk);
        check("status_after_b2b", readData, 32'h0000_0002);
        idle_cycles(2);

        // Overflow: 10 stores, 1 popped, 8 queued, 1 dropped.
        for (int k = 0; k < 10; k++) store(BASE, 32'hA0 + 32'(k));
        dataAddr = STATUS;
        @(negedge clk);
        check("status_overflow", readData, 32'h0000_0805);
        @(posedge clk);
        #1;
        store(STATUS, 32'hFFFF_FFFF);
        dataAddr = STATUS;
        @(negedge clk);
        check("status_ovf_cleared", readData, 32'h0000_0801);
        idle_cycles(9 * 10 * CPB + 10);
        dataAddr = STATUS;
        @(negedge clk);
        check("status_drained", readData, 32'h0000_0002);
        idle_cycles(2);

        // Reset in the middle of 0xA5's data bits with three bytes queued.
        store(BASE, 32'h0000_00A5);
        store(BASE, 32'h0000_0011);
        store(BASE, 32'h0000_0022);
        store(BASE, 32'h0000_0033);
        dataAddr = STATUS;
        @(negedge clk);
        check("status_before_reset", readData, 32'h0000_0300);
        idle_cycles(8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midframe_reset_tx", {31'h0, tx}, 32'h1);
        check("midframe_reset_status", readData, 32'h0000_0002);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("no_frames_after_reset", {31'h0, tx}, 32'h1);
        end

        // Address decode.
        @(posedge clk);
        #1;
        dataAddr  = BASE + 32'd8;
        writeData = 32'h0000_0077;
        we        = 1'b1;
        @(negedge clk);
        check("decode_b8_sel", {31'h0, sel}, 32'h0);
        check("decode_b8_rd", readData, 32'h0);
        @(posedge clk);
        #1;
        we       = 1'b0;
        dataAddr = STATUS;
        @(negedge clk);
        check("decode_b8_nopush", readData, 32'h0000_0002);
        @(posedge clk);
        #1;
        dataAddr = BASE;
        @(negedge clk);
        check("decode_b0_sel", {31'h0, sel}, 32'h1);
        check("decode_b0_rd", readData, 32'h0);
        check("decode_tx_idle", {31'h0, tx}, 32'h1);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
